// File: rtl/vp_debug_clk_ctl_apb.sv
// rtl/vp_debug_clk_ctl_apb.sv - APB register block owning the VP debug clock control word
//
// Purpose:
//   Holds the VP debug clock control word and drives it into the CRCU debug
//   clock generator. A CTL write never reaches the output directly: the gate
//   bit (bit4) is forced high for SETTLE_CYCLES cycles, the new selection is
//   loaded while still gated, then the gate takes the written value.
//
// Optional feature macro: VP_DBG_ID_REG_EN
//   defined   - ID register at 0x08 reads 0x5644_4330
//   undefined - 0x08 is unmapped (pslverr=1, prdata=0)
//
// Ports:
//   CRCU_CLK               block clock, APB is synchronous to it
//   CRCU_RST_N             asynchronous assert, active-low reset
//   psel/penable/pwrite    APB control
//   paddr[ADDR_W-1:0]      byte address
//   pwdata[31:0]           write data
//   prdata[31:0]           read data, valid only while pready=1 on a good read
//   pready                 transfer complete (combinational)
//   pslverr                transfer error (combinational)
//   vp_debug_clock_ctl_reg control word: [2:0] freq, [3] enable, [4] gate

module vp_debug_clk_ctl_apb #(
    parameter int SETTLE_CYCLES = 16,
    parameter int ADDR_W        = 8
) (
    input  logic              CRCU_CLK,
    input  logic              CRCU_RST_N,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [31:0]       pwdata,
    output logic [31:0]       prdata,
    output logic              pready,
    output logic              pslverr,
    output logic [31:0]       vp_debug_clock_ctl_reg
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_GATE = 2'd1;
    localparam logic [1:0] ST_LOAD = 2'd2;

    localparam logic [ADDR_W-1:0] OFF_CTL    = ADDR_W'(8'h00);
    localparam logic [ADDR_W-1:0] OFF_STATUS = ADDR_W'(8'h04);
`ifdef VP_DBG_ID_REG_EN
    localparam logic [ADDR_W-1:0] OFF_ID     = ADDR_W'(8'h08);
    localparam logic [31:0]       ID_VALUE   = 32'h5644_4330;
`endif

    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
    localparam logic [4:0] RESET_WORD  = 5'h10;
    localparam logic [4:0] GATE_BIT    = 5'h10;

    logic [1:0]  state;
    logic [7:0]  cnt;
    logic [4:0]  shadow;
    logic [4:0]  out_word;
    logic        err_sticky;

    logic        access;
    logic        hit_ctl;
    logic        hit_status;
    logic        hit_id;
    logic        mapped;
    logic        bad_sel;
    logic        err;
    logic        stall;
    logic        ctl_wr;
    logic        status_clr;
    logic [31:0] rd_data;
    logic        unused_pwdata;

    assign unused_pwdata = ^pwdata[31:5];

    assign access     = psel & penable;
    assign hit_ctl    = (paddr == OFF_CTL);
    assign hit_status = (paddr == OFF_STATUS);
`ifdef VP_DBG_ID_REG_EN
    assign hit_id     = (paddr == OFF_ID);
`else
    assign hit_id     = 1'b0;
`endif
    assign mapped     = (paddr[1:0] == 2'b00) & (hit_ctl | hit_status | hit_id);
    assign bad_sel    = pwrite & hit_ctl & (pwdata[2:0] > 3'd4);
    assign err        = ~mapped | bad_sel;

    // Any CTL write (good or bad) waits for IDLE so the error/store decision
    // is taken against a quiet FSM; everything else completes at once.
    assign stall      = access & pwrite & hit_ctl & (state != ST_IDLE);
    assign pready     = access & ~stall;
    assign pslverr    = pready & err;

    assign ctl_wr     = pready & pwrite & hit_ctl & ~err;
    assign status_clr = pready & pwrite & hit_status & ~err & pwdata[1];

    always_comb begin
        rd_data = 32'h0;
        if (hit_ctl) begin
            rd_data = {27'h0, shadow};
        end else if (hit_status) begin
            rd_data = {30'h0, err_sticky, (state != ST_IDLE)};
        end
`ifdef VP_DBG_ID_REG_EN
        else if (hit_id) begin
            rd_data = ID_VALUE;
        end
`endif
    end

    assign prdata = (pready & ~err & ~pwrite) ? rd_data : 32'h0;

    assign vp_debug_clock_ctl_reg = {27'h0, out_word};

    always_ff @(posedge CRCU_CLK or negedge CRCU_RST_N) begin
        if (!CRCU_RST_N) begin
            err_sticky <= 1'b0;
        end else if (pslverr) begin
            // a new error beats a same-cycle W1C
            err_sticky <= 1'b1;
        end else if (status_clr) begin
            err_sticky <= 1'b0;
        end
    end

    // The output is registered; its value always tracks the state being
    // entered so GATE/LOAD are visible from the edge that enters them.
    always_ff @(posedge CRCU_CLK or negedge CRCU_RST_N) begin
        if (!CRCU_RST_N) begin
            state    <= ST_IDLE;
            cnt      <= 8'h0;
            shadow   <= RESET_WORD;
            out_word <= RESET_WORD;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ctl_wr) begin
                        shadow   <= pwdata[4:0];
                        out_word <= shadow | GATE_BIT;
                        cnt      <= SETTLE_LOAD;
                        state    <= ST_GATE;
                    end else begin
                        out_word <= shadow;
                    end
                end
                ST_GATE: begin
                    if (cnt == 8'h0) begin
                        // shadow already holds the new selection
                        out_word <= shadow | GATE_BIT;
                        state    <= ST_LOAD;
                    end else begin
                        cnt <= cnt - 8'h1;
                    end
                end
                ST_LOAD: begin
                    out_word <= shadow;
                    state    <= ST_IDLE;
                end
                default: begin
                    out_word <= shadow;
                    cnt      <= 8'h0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vp_debug_clk_ctl_apb.sv
// tb/tb_vp_debug_clk_ctl_apb.sv - scoreboard bench for vp_debug_clk_ctl_apb
module tb_vp_debug_clk_ctl_apb;

    localparam int S = 16;
    localparam logic [31:0] ID_VALUE = 32'h5644_4330;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [7:0]  paddr = 8'h0;
    logic [31:0] pwdata = 32'h0;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic [31:0] ctl_out;

    vp_debug_clk_ctl_apb #(.SETTLE_CYCLES(S), .ADDR_W(8)) dut (
        .CRCU_CLK(clk),
        .CRCU_RST_N(rst_n),
        .psel(psel),
        .penable(penable),
        .pwrite(pwrite),
        .paddr(paddr),
        .pwdata(pwdata),
        .prdata(prdata),
        .pready(pready),
        .pslverr(pslverr),
        .vp_debug_clock_ctl_reg(ctl_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_vec = 0;
    int n_mis = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_mis++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Reference model: shadow word, sticky error, and the time of the last
    // accepted CTL write. The output is derived purely from elapsed edges.
    logic [4:0] m_shadow = 5'h10;
    logic [4:0] m_old    = 5'h10;
    logic       m_sticky = 1'b0;
    bit         m_pend   = 1'b0;
    int         m_wr_edge = 0;

    function automatic logic [31:0] exp_out(input int n);
        int d;
        d = n - m_wr_edge;
        if (m_pend && d >= 0 && d < S) return {27'h0, m_old | 5'h10};
        if (m_pend && d == S)          return {27'h0, m_shadow | 5'h10};
        return {27'h0, m_shadow};
    endfunction

    function automatic bit busy_at(input int n);
        int d;
        d = n - m_wr_edge;
        return m_pend && d >= 0 && d <= S;
    endfunction

    function automatic bit is_err(input bit wr, input logic [7:0] a, input logic [31:0] wd);
        bit mapped;
`ifdef VP_DBG_ID_REG_EN
        mapped = (a == 8'h00) || (a == 8'h04) || (a == 8'h08);
`else
        mapped = (a == 8'h00) || (a == 8'h04);
`endif
        return !mapped || (wr && a == 8'h00 && wd[2:0] > 3'd4);
    endfunction

    typedef struct {
        bit          wr;
        logic [7:0]  addr;
        logic [31:0] wd;
        bit          err;
        logic [31:0] rd;
        int          at;
    } exp_t;

    exp_t q[$];

    // Monitor: checks the output word every cycle and pops the scoreboard
    // whenever a transfer completes, then advances the reference model.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("ctl_out", ctl_out, exp_out(cyc));
            if (!(psel && penable)) begin
                chk("idle_resp", {30'h0, pready, pslverr}, 32'h0);
            end else if (pready) begin
                if (q.size() == 0) begin
                    chk("unexpected_completion", 32'h1, 32'h0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("complete_cycle", cyc, e.at);
                    chk("pslverr", {31'h0, pslverr}, {31'h0, e.err});
                    if (!e.wr) chk("prdata", prdata, e.rd);
                    if (e.err) begin
                        m_sticky = 1'b1;
                    end else if (e.wr && e.addr == 8'h00) begin
                        m_old     = m_shadow;
                        m_shadow  = e.wd[4:0];
                        m_pend    = 1'b1;
                        m_wr_edge = cyc + 1;
                    end else if (e.wr && e.addr == 8'h04 && e.wd[1]) begin
                        m_sticky = 1'b0;
                    end
                end
            end
        end
    end

    task automatic apb(input bit wr, input logic [7:0] a, input logic [31:0] wd);
        exp_t e;
        bit done;
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd;
        @(posedge clk); #1;
        penable = 1'b1;
        e.wr = wr; e.addr = a; e.wd = wd;
        e.err = is_err(wr, a, wd);
        e.at = cyc;
        if (wr && a == 8'h00) begin
            while (busy_at(e.at)) e.at++;
        end
        e.rd = 32'h0;
        if (!wr && !e.err) begin
            case (a)
                8'h00:   e.rd = {27'h0, m_shadow};
                8'h04:   e.rd = {30'h0, m_sticky, busy_at(e.at)};
                default: e.rd = ID_VALUE;
            endcase
        end
        q.push_back(e);
        done = 1'b0;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (pready) done = 1'b1;
        end
        if (!done) begin
            chk("pready_timeout", 32'h0, 32'h1);
            void'(q.pop_front());
        end
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    logic [7:0] addr_pool [10] = '{8'h00, 8'h00, 8'h00, 8'h04, 8'h04, 8'h08, 8'h0C, 8'h01, 8'h02, 8'h10};

    initial begin
        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out", ctl_out, 32'h10);
        chk("rst_pready", {31'h0, pready}, 32'h0);
        chk("rst_pslverr", {31'h0, pslverr}, 32'h0);
        chk("rst_prdata", prdata, 32'h0);
        @(negedge clk); #2;
        rst_n = 1'b1;
        apb(0, 8'h00, 0);
        apb(0, 8'h04, 0);

        // first update, then a second CTL write while the first is settling
        apb(1, 8'h00, 32'h0B);
        repeat (1) @(posedge clk);
        apb(1, 8'h00, 32'h0C);
        repeat (S + 3) @(posedge clk);
        apb(0, 8'h00, 0);
        apb(0, 8'h04, 0);

        // bad frequency select, sticky error, W1C
        apb(1, 8'h00, 32'h0D);
        apb(0, 8'h04, 0);
        apb(1, 8'h04, 32'h2);
        apb(0, 8'h04, 0);

        // ID / unmapped / misaligned
        apb(0, 8'h08, 0);
        apb(0, 8'h0C, 0);
        apb(0, 8'h01, 0);
        apb(1, 8'h04, 32'h2);

        // randomized traffic
        for (int i = 0; i < 60; i++) begin
            bit wr;
            logic [7:0] a;
            logic [31:0] wd;
            wr = 1'($urandom_range(0, 1));
            a  = addr_pool[$urandom_range(0, 9)];
            wd = $urandom;
            if ($urandom_range(0, 3) != 0) wd[2:0] = 3'($urandom_range(0, 4));
            apb(wr, a, wd);
            repeat ($urandom_range(0, 20)) @(posedge clk);
        end
        repeat (S + 3) @(posedge clk);

        // reset asserted five cycles into GATE
        apb(1, 8'h00, 32'h03);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out", ctl_out, 32'h10);
        m_pend = 1'b0; m_shadow = 5'h10; m_old = 5'h10; m_sticky = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); #2;
        rst_n = 1'b1;
        apb(0, 8'h04, 0);
        apb(0, 8'h00, 0);
        repeat (3) @(posedge clk);
        chk("queue_empty", q.size(), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
